// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the rate-1/2, 4-state Viterbi decoder: paces ACS steps per
// accepted symbol, runs one traceback per frame and hands the decoded byte out.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN  = 8,
  parameter int TB_TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_sym_valid,
  input  logic [1:0] i_sym,
  output logic       o_sym_ready,
  output logic [1:0] o_sym,
  output logic       o_en_acs,
  output logic [2:0] o_wr_addr,
  output logic       o_acs_clear,
  output logic       o_en_traceback,
  output logic [2:0] o_rd_addr,
  input  logic       i_tb_done,
  input  logic [7:0] i_tb_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_err,
  output logic [2:0] o_dbg_state
);

  localparam int TW = $clog2(TB_TIMEOUT + 1);
  localparam logic [2:0]    LAST_STEP = 3'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACS    = 3'd2,
    S_FLUSH  = 3'd3,
    S_TRACE  = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    sym_q, sym_d;
  logic          sym_ready_q, sym_ready_d;
  logic          en_acs_q, en_acs_d;
  logic [2:0]    wr_addr_q, wr_addr_d;
  logic          acs_clear_q, acs_clear_d;
  logic          en_tb_q, en_tb_d;
  logic [2:0]    rd_addr_q, rd_addr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          sym_hs;

  // Symbol handshake: a pair transfers on a rising edge where i_sym_valid and
  // o_sym_ready are both high; byte handshake likewise on o_valid and i_ready.
  assign sym_hs = i_sym_valid & sym_ready_q;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    tmo_d     = tmo_q;
    sym_d     = sym_q;
    en_acs_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        step_d  = 3'd0;
        state_d = S_ACS;
      end
      S_ACS: begin
        if (sym_hs) begin
          sym_d     = i_sym;
          en_acs_d  = 1'b1;
          wr_addr_d = step_q;
          step_d    = step_q + 3'd1;
          if (step_q == LAST_STEP) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        tmo_d     = '0;
        rd_addr_d = LAST_STEP;
        state_d   = S_TRACE;
      end
      S_TRACE: begin
        rd_addr_d = (rd_addr_q == 3'd0) ? 3'd0 : rd_addr_q - 3'd1;
        // A done arriving on the last allowed cycle still delivers the byte.
        if (i_tb_done) begin
          data_d  = i_tb_data;
          valid_d = 1'b1;
          state_d = S_OUTPUT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = i_enable ? S_CLEAR : S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_OUTPUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = i_enable ? S_CLEAR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sym_ready_d = (state_d == S_ACS);
    acs_clear_d = (state_d == S_CLEAR);
    en_tb_d     = (state_d == S_TRACE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      tmo_q       <= '0;
      sym_q       <= '0;
      sym_ready_q <= 1'b0;
      en_acs_q    <= 1'b0;
      wr_addr_q   <= '0;
      acs_clear_q <= 1'b0;
      en_tb_q     <= 1'b0;
      rd_addr_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tmo_q       <= tmo_d;
      sym_q       <= sym_d;
      sym_ready_q <= sym_ready_d;
      en_acs_q    <= en_acs_d;
      wr_addr_q   <= wr_addr_d;
      acs_clear_q <= acs_clear_d;
      en_tb_q     <= en_tb_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_sym_ready    = sym_ready_q;
  assign o_sym          = sym_q;
  assign o_en_acs       = en_acs_q;
  assign o_wr_addr      = wr_addr_q;
  assign o_acs_clear    = acs_clear_q;
  assign o_en_traceback = en_tb_q;
  assign o_rd_addr      = rd_addr_q;
  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_busy         = busy_q;
  assign o_err          = err_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl: ACS step/byte scoreboards plus
// directed timing checks for traceback, timeout, output hold and reset.
module tb_viterbi_frame_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_enable, i_sym_valid, i_tb_done, i_ready;
  logic [1:0] i_sym;
  logic [7:0] i_tb_data;
  logic       o_sym_ready, o_en_acs, o_acs_clear, o_en_traceback;
  logic       o_valid, o_busy, o_err;
  logic [1:0] o_sym;
  logic [2:0] o_wr_addr, o_rd_addr, o_dbg_state;
  logic [7:0] o_data;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acs_cnt, first_acs, last_acs;
  int exp_addr;
  logic exp_err;
  logic [1:0] syms [8];
  logic [4:0] exp_q [$];
  logic [7:0] exp_byte_q [$];

  viterbi_frame_ctrl #(.FRAME_LEN(8), .TB_TIMEOUT(12)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_sym_valid(i_sym_valid), .i_sym(i_sym), .o_sym_ready(o_sym_ready),
    .o_sym(o_sym), .o_en_acs(o_en_acs), .o_wr_addr(o_wr_addr),
    .o_acs_clear(o_acs_clear), .o_en_traceback(o_en_traceback),
    .o_rd_addr(o_rd_addr), .i_tb_done(i_tb_done), .i_tb_data(i_tb_data),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor on the falling edge, away from input changes.
  always @(negedge clk) begin
    logic [4:0] e;
    logic [7:0] b;
    if (o_en_acs) begin
      if (exp_q.size() == 0) check("acs_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", {29'd0, o_wr_addr}, {29'd0, e[4:2]});
        check("sym", {30'd0, o_sym}, {30'd0, e[1:0]});
      end
      if (acs_cnt == 0) first_acs = cyc;
      last_acs = cyc;
      acs_cnt++;
    end
    if (o_valid && i_ready) begin
      if (exp_byte_q.size() == 0) check("byte_unexpected", 32'd1, 32'd0);
      else begin
        b = exp_byte_q.pop_front();
        check("byte", {24'd0, o_data}, {24'd0, b});
      end
    end
  end

  // Driver tasks
  task automatic send_sym(input logic [1:0] s);
    int n = 0;
    i_sym_valid = 1'b1;
    i_sym       = s;
    while (!o_sym_ready && n < 40) begin
      tick();
      n++;
    end
    if (!o_sym_ready) check("ready_timeout", 32'd0, 32'd1);
    exp_q.push_back({3'(exp_addr), s});
    exp_addr++;
    tick();
  endtask

  task automatic run_frame(input int gap_after, input int gap_len, input int done_cyc,
                           input logic [7:0] data, input int hold, input logic en_after);
    i_enable = 1'b1;
    exp_addr = 0;
    acs_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == gap_after && gap_len > 0) begin
        i_sym_valid = 1'b0;
        repeat (gap_len) tick();
      end
      send_sym(syms[i]);
    end
    i_sym_valid = 1'b0;
    check("flush_state", {29'd0, o_dbg_state}, {29'd0, ST_FLUSH});
    check("flush_ready", {31'd0, o_sym_ready}, 32'd0);
    i_enable = en_after;
    tick();
    check("acs_count", acs_cnt, 32'd8);
    check("acs_span", last_acs - first_acs, 7 + gap_len);
    for (int k = 1; k <= 12; k++) begin
      check("tb_en", {31'd0, o_en_traceback}, 32'd1);
      check("rd_addr", {29'd0, o_rd_addr}, (k <= 8) ? 8 - k : 0);
      check("err_trace", {31'd0, o_err}, {31'd0, exp_err});
      if (k == done_cyc) begin
        i_tb_done = 1'b1;
        i_tb_data = data;
        exp_byte_q.push_back(data);
        tick();
        i_tb_done = 1'b0;
        i_tb_data = $urandom_range(0, 255);
        break;
      end
      tick();
      if (k == 12) begin
        exp_err = 1'b1;
        check("tmo_err", {31'd0, o_err}, 32'd1);
        check("tmo_valid", {31'd0, o_valid}, 32'd0);
        check("tmo_state", {29'd0, o_dbg_state}, en_after ? ST_CLEAR : ST_IDLE);
        return;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      check("out_state", {29'd0, o_dbg_state}, {29'd0, ST_OUT});
      check("out_valid", {31'd0, o_valid}, 32'd1);
      check("out_data", {24'd0, o_data}, {24'd0, data});
      check("out_tb_en", {31'd0, o_en_traceback}, 32'd0);
      check("out_err", {31'd0, o_err}, {31'd0, exp_err});
      if (h == hold) i_ready = 1'b1;
      tick();
    end
    i_ready = 1'b0;
    check("post_valid", {31'd0, o_valid}, 32'd0);
    check("post_clear", {31'd0, o_acs_clear}, {31'd0, en_after});
    check("post_busy", {31'd0, o_busy}, {31'd0, en_after});
    if (en_after) begin
      tick();
      check("ready_v2", {31'd0, o_sym_ready}, 32'd1);
    end
  endtask

  task automatic rand_syms();
    for (int i = 0; i < 8; i++) syms[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {o_sym_ready, o_sym, o_en_acs, o_wr_addr, o_acs_clear, o_en_traceback,
                o_rd_addr, o_data, o_valid, o_busy, o_err, o_dbg_state}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b0; i_sym_valid = 1'b0; i_sym = 2'd0;
    i_tb_done = 1'b0; i_tb_data = 8'd0; i_ready = 1'b0;
    exp_err = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, o_busy}, 32'd0);

    // Directed pattern, byte 0xA5 on 9th TRACE cycle, consumer stalls 4 cycles.
    syms[0] = 2'b00; syms[1] = 2'b11; syms[2] = 2'b10; syms[3] = 2'b00;
    syms[4] = 2'b01; syms[5] = 2'b11; syms[6] = 2'b00; syms[7] = 2'b10;
    run_frame(-1, 0, 9, 8'hA5, 4, 1'b1);

    // 3-cycle source gap after the 4th symbol.
    rand_syms();
    run_frame(4, 3, 3, 8'($urandom_range(0, 255)), 0, 1'b1);

    // Traceback never completes, then a normal frame with sticky error.
    rand_syms();
    run_frame(-1, 0, 0, 8'h00, 0, 1'b1);
    rand_syms();
    run_frame(2, 1, 5, 8'($urandom_range(0, 255)), 1, 1'b1);

    // Reset during ACS step 5.
    rand_syms();
    exp_addr = 0;
    for (int i = 0; i < 5; i++) send_sym(syms[i]);
    i_sym_valid = 1'b1;
    i_sym = 2'b11;
    rst = 1'b1;
    tick();
    check_all_zero("mid_frame_reset");
    check("sb_empty_rst", exp_q.size(), 32'd0);
    rst = 1'b0;
    i_sym_valid = 1'b0;
    exp_err = 1'b0;

    // Restart, done coincident with the 12th TRACE cycle, end with enable low.
    rand_syms();
    run_frame(-1, 0, 12, 8'h3C, 2, 1'b0);
    tick();
    check("final_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    check("final_err", {31'd0, o_err}, 32'd0);
    check("sb_empty_acs", exp_q.size(), 32'd0);
    check("sb_empty_byte", exp_byte_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer for the rate-1/2, 4-state Viterbi decoder. It accepts coded symbol pairs over a valid/ready handshake and drives the ACS stage one trellis step per accepted symbol. After a frame of 8 steps it enables the traceback/output stage for one frame and returns the decoded byte over a second valid/ready handshake. It sits between the symbol source and the branch-metric/ACS/traceback datapath, and is the only block that asserts the ACS and traceback enables.

## Interface
Parameters:
- FRAME_LEN, 8: trellis steps per frame. Fixed at 8 because traceback emits one 8-bit byte; address width is 3.
- TB_TIMEOUT, 12: maximum cycles in TRACE waiting for `i_tb_done` before abort.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  permits a new frame to start.
- `i_sym_valid`  in  1  symbol pair available.
- `i_sym`  in  2  coded symbol pair.
- `o_sym_ready`  out  1  controller accepts a symbol this cycle.
- `o_sym`  out  2  registered symbol to the branch-metric unit.
- `o_en_acs`  out  1  one-cycle ACS update strobe.
- `o_wr_addr`  out  3  survivor-memory write index for the current `o_en_acs`.
- `o_acs_clear`  out  1  clears ACS path metrics before a frame.
- `o_en_traceback`  out  1  traceback enable, held through TRACE.
- `o_rd_addr`  out  3  survivor-memory read index during traceback.
- `i_tb_done`  in  1  traceback byte complete.
- `i_tb_data`  in  8  traceback byte.
- `o_data`  out  8  decoded byte.
- `o_valid`  out  1  decoded byte available.
- `i_ready`  in  1  consumer accepts the byte.
- `o_busy`  out  1  high in every state except IDLE.
- `o_err`  out  1  sticky traceback-timeout flag; cleared only by `rst`.

## Operation
- All outputs are registered. Reset value of every output is 0; the state resets to IDLE.
- FSM states: IDLE, CLEAR, ACS, FLUSH, TRACE, OUTPUT.
  - IDLE: if `i_enable`, go to CLEAR.
  - CLEAR: lasts 1 cycle with `o_acs_clear`=1. Zeroes the step counter. Go to ACS.
  - ACS: `o_sym_ready`=1.
    - Each handshake (`i_sym_valid & o_sym_ready`) captures `i_sym` into `o_sym`.
    - The following cycle, `o_en_acs`=1 and `o_wr_addr`=step index (0..7).
    - The step counter increments after each handshake.
    - On the 8th handshake, `o_sym_ready` drops and the state goes to FLUSH.
    - Gaps in `i_sym_valid` stall the frame with no limit.
  - FLUSH: 1 cycle. Carries the final `o_en_acs` (step 7); `o_sym_ready`=0. Go to TRACE.
  - TRACE: `o_en_traceback`=1.
    - `o_rd_addr` starts at 7 and decrements each cycle, saturating at 0.
    - Timeout counter increments each cycle.
    - On `i_tb_done`: capture `i_tb_data` into `o_data`, set `o_valid`=1, go to OUTPUT.
    - If the counter reaches TB_TIMEOUT without `i_tb_done`: set `o_err`, discard the frame, go to CLEAR (or IDLE if `i_enable`=0).
  - OUTPUT: `o_en_traceback`=0; `o_valid` and `o_data` are held stable until `i_ready`. On the handshake, `o_valid`=0 and the next state is CLEAR if `i_enable`, else IDLE.
- `i_sym_valid` is ignored outside ACS. `i_tb_done` is ignored outside TRACE.
- `i_enable` is sampled only in IDLE and at frame end. Dropping it mid-frame does not abort the frame.
- If `i_tb_done` arrives in the same cycle the timeout would fire, `i_tb_done` wins and `o_err` is not set.
- `rst` asserted in any state forces IDLE and all outputs to 0 on the next edge, including `o_err`.

## Timing
- Symbol handshake at cycle t → `o_en_acs`, `o_sym`, `o_wr_addr` valid at t+1.
- 8th handshake at t → FLUSH at t+1 (`o_en_acs`=1, addr 7) → TRACE at t+2 with `o_en_traceback`=1 and `o_rd_addr`=7.
- `i_tb_done` at cycle u → `o_valid`=1 and `o_data` valid at u+1.
- Earliest byte handshake is u+1. After a byte handshake at v, CLEAR is at v+1 and `o_sym_ready`=1 at v+2.
- Minimum frame, with source always valid and `i_tb_done` after 9 TRACE cycles: 1 (CLEAR) + 8 (ACS) + 1 (FLUSH) + 9 (TRACE) + 1 (OUTPUT) = 20 cycles.

## Test plan
- Reset, then `i_enable`=1 and 8 back-to-back symbols 00,11,10,00,01,11,00,10 → `o_en_acs` pulses 8 consecutive cycles with `o_wr_addr` 0..7 and `o_sym` matching input order. `o_en_traceback` rises 2 cycles after the 8th handshake.
- Insert a 3-cycle `i_sym_valid` gap after symbol 4 → `o_en_acs` also gaps 3 cycles; addresses stay contiguous 0..7 and no symbol is dropped.
- `i_tb_done` with `i_tb_data`=0xA5 on the 9th TRACE cycle and `i_ready` held 0 for 4 cycles → `o_valid`=1 with `o_data`=0xA5 stable for 5 cycles. `o_acs_clear` pulses the cycle after `i_ready`=1.
- Never assert `i_tb_done` → after exactly 12 TRACE cycles `o_err`=1 and `o_valid` stays 0. The next frame proceeds normally and `o_err` stays 1 until `rst`.
- Assert `rst` during ACS step 5 → next cycle all outputs are 0 and the state is IDLE. The frame restarts at `o_wr_addr`=0 after `i_enable`.
- `i_tb_done` coincident with the 12th TRACE cycle → byte delivered and `o_err` stays 0.
